cir_peak_detector: RTL

- Downstream stage of the complex FIR correlator in the channel sounder.
- Consumes the filtered complex impulse-response stream one frame at a time, where each frame ends at `tlast`.
- Computes the instantaneous power I²+Q² of every sample and tracks the strongest tap and its position in the frame.
- Emits one two-beat AXI-Stream result per frame: peak power, then peak index / frame length; software uses it for delay estimation.

---
 rtl/cir_peak_pkg.sv | 31 +++
 rtl/cplx_mag_sq.sv | 63 ++++++
 rtl/cir_peak_detector.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cir_peak_pkg.sv
// Shared widths, beat-1 field layout and output state type for the CIR peak detector.
package cir_peak_pkg;

   localparam int IQ_W    = 32;
   localparam int PWR_W   = 64;
   localparam int IDX_W   = 16;

   localparam int IDX_LSB = 0;
   localparam int LEN_LSB = 32;
   localparam int OVF_BIT = 63;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BEAT0 = 2'd1,
      ST_BEAT1 = 2'd2
   } out_state_e;

   function automatic logic [PWR_W-1:0] pack_beat1(
      input logic [IDX_W-1:0] idx,
      input logic [IDX_W-1:0] len_m1,
      input logic             ovf
   );
      logic [PWR_W-1:0] w;
      w                     = '0;
      w[IDX_LSB +: IDX_W]   = idx;
      w[LEN_LSB +: IDX_W]   = len_m1;
      w[OVF_BIT]            = ovf;
      return w;
   endfunction

endpackage

// File: rtl/cplx_mag_sq.sv
// Two-stage |x|^2 pipeline: P1 squares I and Q, P2 sums them. Valid/last ride alongside.
module cplx_mag_sq
   import cir_peak_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             valid_i,
   input  logic             last_i,
   input  logic [IQ_W-1:0]  i_i,
   input  logic [IQ_W-1:0]  q_i,
   output logic [PWR_W-1:0] pwr_o,
   output logic             valid_o,
   output logic             last_o
);

   logic [IQ_W-1:0]  comp [2];
   logic             v1_q, l1_q;
   logic             v2_q, l2_q;
   logic [PWR_W-1:0] pwr_q;

   assign comp[0] = i_i;
   assign comp[1] = q_i;

   // A square of a 32-bit two's complement value is at most 2^62, so 63 bits hold it.
   for (genvar gi = 0; gi < 2; gi++) begin : g_sq
      logic signed [2*IQ_W-1:0] prod;
      logic [PWR_W-2:0]         sq_q;
      logic                     unused_msb;

      assign prod       = $signed(comp[gi]) * $signed(comp[gi]);
      assign unused_msb = prod[2*IQ_W-1];

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            sq_q <= '0;
         end else if (en_i) begin
            sq_q <= prod[PWR_W-2:0];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         v1_q  <= 1'b0;
         l1_q  <= 1'b0;
         v2_q  <= 1'b0;
         l2_q  <= 1'b0;
         pwr_q <= '0;
      end else if (en_i) begin
         v1_q  <= valid_i;
         l1_q  <= last_i;
         v2_q  <= v1_q;
         l2_q  <= l1_q;
         pwr_q <= {1'b0, g_sq[0].sq_q} + {1'b0, g_sq[1].sq_q};
      end
   end

   assign pwr_o   = pwr_q;
   assign valid_o = v2_q;
   assign last_o  = l2_q;

endmodule

// File: rtl/cir_peak_detector.sv
// Per-frame peak power tracker for the correlator output; emits power, then index/length,
// as a two-beat AXI-Stream result once the frame's tlast reaches the compare stage.
module cir_peak_detector #(
   parameter int C_S00_AXIS_TDATA_WIDTH = 64,
   parameter int C_M00_AXIS_TDATA_WIDTH = 64,
   parameter int IDX_W                  = cir_peak_pkg::IDX_W
) (
   input  logic                                axis_aclk,
   input  logic                                axis_areset,
   input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
   input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
   input  logic                                s00_axis_tlast,
   input  logic                                s00_axis_tvalid,
   output logic                                s00_axis_tready,
   output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
   output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
   output logic                                m00_axis_tlast,
   output logic                                m00_axis_tvalid,
   input  logic                                m00_axis_tready
);

   import cir_peak_pkg::*;

   localparam logic [IDX_W-1:0] CNT_MAX = '1;

   logic             en;
   logic [PWR_W-1:0] p2_pwr;
   logic             p2_valid;
   logic             p2_last;
   logic             p3_fire;
   logic             unused_tstrb;

   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] best_idx_q, best_idx_d;
   logic [PWR_W-1:0] best_pwr_q, best_pwr_d;
   logic             ovf_q, ovf_d;
   logic             take;

   out_state_e       state_q;
   logic             m_valid_q;
   logic             m_last_q;
   logic [PWR_W-1:0] m_data_q;
   logic [PWR_W-1:0] beat1_q;

   assign unused_tstrb    = ^s00_axis_tstrb;
   assign en              = (state_q == ST_IDLE);
   assign s00_axis_tready = en;

   cplx_mag_sq u_mag_sq (
      .clk_i   (axis_aclk),
      .rst_i   (axis_areset),
      .en_i    (en),
      .valid_i (s00_axis_tvalid),
      .last_i  (s00_axis_tlast),
      .i_i     (s00_axis_tdata[IQ_W-1:0]),
      .q_i     (s00_axis_tdata[2*IQ_W-1:IQ_W]),
      .pwr_o   (p2_pwr),
      .valid_o (p2_valid),
      .last_o  (p2_last)
   );

   assign p3_fire = en && p2_valid;

   // cnt only returns to zero at a frame boundary (it saturates rather than wraps),
   // so cnt == 0 identifies the first sample of a frame.
   always_comb begin
      take       = (cnt_q == '0) || (p2_pwr > best_pwr_q);
      best_pwr_d = take ? p2_pwr : best_pwr_q;
      best_idx_d = take ? cnt_q  : best_idx_q;
      cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      ovf_d      = ovf_q | (cnt_q == CNT_MAX);
   end

   always_ff @(posedge axis_aclk or posedge axis_areset) begin
      if (axis_areset) begin
         cnt_q      <= '0;
         best_idx_q <= '0;
         best_pwr_q <= '0;
         ovf_q      <= 1'b0;
      end else if (p3_fire) begin
         if (p2_last) begin
            cnt_q      <= '0;
            best_idx_q <= '0;
            best_pwr_q <= '0;
            ovf_q      <= 1'b0;
         end else begin
            cnt_q      <= cnt_d;
            best_idx_q <= best_idx_d;
            best_pwr_q <= best_pwr_d;
            ovf_q      <= ovf_d;
         end
      end
   end

   // The tlast sample's own contribution is folded in via the _d values; its index
   // (cnt_q) doubles as the saturated frame length minus one.
   always_ff @(posedge axis_aclk or posedge axis_areset) begin
      if (axis_areset) begin
         state_q   <= ST_IDLE;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         m_data_q  <= '0;
         beat1_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (p3_fire && p2_last) begin
                  state_q   <= ST_BEAT0;
                  m_valid_q <= 1'b1;
                  m_last_q  <= 1'b0;
                  m_data_q  <= best_pwr_d;
                  beat1_q   <= pack_beat1(best_idx_d, cnt_q, ovf_d);
               end
            end
            ST_BEAT0: begin
               if (m00_axis_tready) begin
                  state_q  <= ST_BEAT1;
                  m_last_q <= 1'b1;
                  m_data_q <= beat1_q;
               end
            end
            ST_BEAT1: begin
               if (m00_axis_tready) begin
                  state_q   <= ST_IDLE;
                  m_valid_q <= 1'b0;
                  m_last_q  <= 1'b0;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               m_valid_q <= 1'b0;
               m_last_q  <= 1'b0;
            end
         endcase
      end
   end

   assign m00_axis_tdata  = m_data_q;
   assign m00_axis_tstrb  = '1;
   assign m00_axis_tlast  = m_last_q;
   assign m00_axis_tvalid = m_valid_q;

endmodule
